dec_onehot_scan: RTL and testbench

- Parametrised registered binary-to-one-hot decoder. It generalises the team's combinational 2-to-4 decoder to SEL_W select bits and NUM_OUT outputs.
- Adds an autonomous scan mode: a prescaled internal index walks the outputs, for digit/row multiplexing.
- Sits between control logic and display/row-select drivers.
- Output is registered; out_valid is a one-cycle handshake pulse per update.

---
 rtl/dec_onehot_scan.sv | 104 ++++++++++
 tb/tb_dec_onehot_scan.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_onehot_scan.sv
// Registered binary-to-one-hot decoder with an autonomous prescaled scan mode
// for digit/row multiplexing; out_valid pulses once per y/idx update.
module dec_onehot_scan #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DIV_W-1:0]   div,
  input  logic               err_clr,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               out_valid,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam logic [SEL_W:0]   NUM_OUT_X = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [SEL_W-1:0] scan_start;
  logic [SEL_W-1:0] scan_next;

  function automatic logic in_range(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < NUM_OUT_X);
  endfunction

  function automatic logic [NUM_OUT-1:0] to_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_OUT-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (s == SEL_W'(k)) r[k] = 1'b1;
    end
    return r;
  endfunction

  // Wraps at the last output; an out-of-range index also folds back to 0.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
    return (s >= LAST_IDX) ? '0 : s + SEL_W'(1);
  endfunction

  assign scan_start = in_range(idx) ? idx : '0;
  assign scan_next  = wrap_inc(idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      // Clear first so a same-edge out-of-range request overrides it.
      if (err_clr) err <= 1'b0;

      if (!en) begin
        state     <= IDLE;
        y         <= '0;
        out_valid <= 1'b0;
        cnt       <= '0;
      end else if (!mode) begin
        state     <= DIRECT;
        cnt       <= '0;
        out_valid <= in_valid;
        if (in_valid) begin
          if (in_range(sel)) begin
            y   <= to_onehot(sel);
            idx <= sel;
          end else begin
            y   <= '0;
            err <= 1'b1;
          end
        end
      end else begin
        state <= SCAN;
        if (state != SCAN) begin
          idx       <= scan_start;
          y         <= to_onehot(scan_start);
          cnt       <= '0;
          out_valid <= 1'b1;
        end else if (cnt >= div) begin
          // >= so that lowering div below the running count steps at once.
          cnt       <= '0;
          idx       <= scan_next;
          y         <= to_onehot(scan_next);
          out_valid <= 1'b1;
        end else begin
          cnt       <= cnt + DIV_W'(1);
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Bench for dec_onehot_scan: a 4-output instance driven through direct, scan and
// transition scenarios against a pulse scoreboard, plus a 5-output instance for range errors.
module tb_dec_onehot_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       en4, mode4, iv4, clr4;
  logic [1:0] sel4;
  logic [7:0] div4;
  logic [3:0] y4;
  logic [1:0] idx4;
  logic       ov4, err4;

  logic       en5, mode5, iv5, clr5;
  logic [2:0] sel5;
  logic [7:0] div5;
  logic [4:0] y5;
  logic [2:0] idx5;
  logic       ov5, err5;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    logic [3:0] y;
    logic [1:0] idx;
    int         cyc;
  } exp_t;

  exp_t q[$];

  dec_onehot_scan #(.SEL_W(2), .NUM_OUT(4), .DIV_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .in_valid(iv4),
    .sel(sel4), .div(div4), .err_clr(clr4),
    .y(y4), .idx(idx4), .out_valid(ov4), .err(err4)
  );

  dec_onehot_scan #(.SEL_W(3), .NUM_OUT(5), .DIV_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .in_valid(iv5),
    .sel(sel5), .div(div5), .err_clr(clr5),
    .y(y5), .idx(idx5), .out_valid(ov5), .err(err5)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (!$onehot0(y4) || !$onehot0(y5)) begin
        failures++;
        $display("FAIL onehot0 cyc=%0d y4=%b y5=%b required zero-or-one-hot", cyc, y4, y5);
      end
      if (ov4 === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d y=%b idx=%0d required no pulse", cyc, y4, idx4);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (y4 !== e.y || idx4 !== e.idx || cyc != e.cyc) begin
            failures++;
            $display("FAIL pulse got y=%b idx=%0d cyc=%0d required y=%b idx=%0d cyc=%0d",
                     y4, idx4, cyc, e.y, e.idx, e.cyc);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_pulse cyc=%0d out_valid=%b required pulse y=%b idx=%0d",
                 cyc, ov4, e.y, e.idx);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input int at);
    exp_t e;
    e.y   = 4'(4'b0001 << k);
    e.idx = 2'(k);
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    en4 = 0; mode4 = 0; iv4 = 0; clr4 = 0; sel4 = '0; div4 = '0;
    en5 = 0; mode5 = 0; iv5 = 0; clr5 = 0; sel5 = '0; div5 = '0;
    repeat (2) tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y4, idx4, ov4, err4} !== 8'b0) begin
      failures++;
      $display("FAIL reset_dut4 got y=%b idx=%b ov=%b err=%b required all zero", y4, idx4, ov4, err4);
    end
    checks++;
    if ({y5, idx5, ov5, err5} !== 10'b0) begin
      failures++;
      $display("FAIL reset_dut5 got y=%b idx=%b ov=%b err=%b required all zero", y5, idx5, ov5, err5);
    end
    tick;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    repeat (5) begin
      tick;
      @(negedge clk);
      checks++;
      if (y4 !== 4'b0 || ov4 !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset got y=%b ov=%b required y=0000 ov=0", y4, ov4);
      end
    end
  endtask

  task automatic test_direct_sweep;
    en4 = 1; mode4 = 0;
    for (int k = 0; k < 4; k++) begin
      iv4 = 1; sel4 = 2'(k);
      push_exp(k, cyc + 1);
      tick;
    end
    iv4 = 0;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if (y4 !== 4'b1000 || idx4 !== 2'd3 || ov4 !== 1'b0) begin
      failures++;
      $display("FAIL sweep_hold got y=%b idx=%0d ov=%b required y=1000 idx=3 ov=0", y4, idx4, ov4);
    end
    tick;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sweep_drain pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_back_to_back;
    int last;
    last = 3;
    for (int n = 0; n < 24; n++) begin
      iv4  = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      sel4 = 2'($urandom_range(0, 3));
      if (iv4) begin
        push_exp(int'(sel4), cyc + 1);
        last = int'(sel4);
      end
      tick;
    end
    iv4 = 0;
    for (int w = 0; w < 10 && q.size() != 0; w++) tick;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain pending=%0d required 0", q.size());
      q.delete();
    end
    @(negedge clk);
    checks++;
    if (y4 !== 4'(4'b0001 << last) || idx4 !== 2'(last)) begin
      failures++;
      $display("FAIL b2b_hold got y=%b idx=%0d required idx=%0d", y4, idx4, last);
    end
  endtask

  task automatic test_out_of_range;
    en5 = 1; mode5 = 0; iv5 = 1; sel5 = 3'd3; clr5 = 0;
    tick;
    @(negedge clk);
    checks++;
    if (y5 !== 5'b01000 || idx5 !== 3'd3 || ov5 !== 1'b1 || err5 !== 1'b0) begin
      failures++;
      $display("FAIL oor_valid got y=%b idx=%0d ov=%b err=%b required 01000 3 1 0", y5, idx5, ov5, err5);
    end
    sel5 = 3'd6;
    tick;
    @(negedge clk);
    checks++;
    if (y5 !== 5'b0 || idx5 !== 3'd3 || ov5 !== 1'b1 || err5 !== 1'b1) begin
      failures++;
      $display("FAIL oor_sel6 got y=%b idx=%0d ov=%b err=%b required 00000 3 1 1", y5, idx5, ov5, err5);
    end
    iv5 = 0;
    tick;
    @(negedge clk);
    checks++;
    if (err5 !== 1'b1 || ov5 !== 1'b0) begin
      failures++;
      $display("FAIL oor_sticky got err=%b ov=%b required err=1 ov=0", err5, ov5);
    end
    iv5 = 1; sel5 = 3'd7; clr5 = 1;
    tick;
    @(negedge clk);
    checks++;
    if (err5 !== 1'b1 || y5 !== 5'b0 || ov5 !== 1'b1) begin
      failures++;
      $display("FAIL oor_set_wins got err=%b y=%b ov=%b required err=1 y=00000 ov=1", err5, y5, ov5);
    end
    iv5 = 0;
    tick;
    @(negedge clk);
    checks++;
    if (err5 !== 1'b0 || idx5 !== 3'd3) begin
      failures++;
      $display("FAIL oor_clear got err=%b idx=%0d required err=0 idx=3", err5, idx5);
    end
    clr5 = 0; en5 = 0;
  endtask

  task automatic test_scan_wrap;
    int base;
    en4 = 0; iv4 = 0;
    tick;
    en4 = 1; mode4 = 0; iv4 = 1; sel4 = 2'd0;
    push_exp(0, cyc + 1);
    tick;
    iv4 = 0; mode4 = 1; div4 = 8'd2;
    base = cyc + 1;
    push_exp(0, base);
    for (int k = 1; k <= 4; k++) push_exp(k % 4, base + 3 * k);
    while (cyc < base + 12) tick;
    en4 = 0;
    tick;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scan_wrap_drain pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_div_change;
    int base;
    en4 = 1; mode4 = 1; div4 = 8'd0;
    base = cyc + 1;
    for (int k = 0; k < 4; k++) push_exp(k, base + k);
    while (cyc < base + 3) tick;
    div4 = 8'd9;
    while (cyc < base + 9) tick;
    div4 = 8'd3;
    push_exp(0, base + 10);
    push_exp(1, base + 14);
    push_exp(2, base + 18);
    while (cyc < base + 18) tick;
  endtask

  task automatic test_mode_transitions;
    mode4 = 0; iv4 = 0;
    tick;
    @(negedge clk);
    checks++;
    if (y4 !== 4'b0100 || idx4 !== 2'd2 || ov4 !== 1'b0) begin
      failures++;
      $display("FAIL scan_to_direct got y=%b idx=%0d ov=%b required 0100 2 0", y4, idx4, ov4);
    end
    tick; tick;
    @(negedge clk);
    checks++;
    if (y4 !== 4'b0100) begin
      failures++;
      $display("FAIL direct_hold got y=%b required 0100", y4);
    end
    en4 = 0;
    tick;
    @(negedge clk);
    checks++;
    if (y4 !== 4'b0 || idx4 !== 2'd2 || ov4 !== 1'b0) begin
      failures++;
      $display("FAIL disable got y=%b idx=%0d ov=%b required 0000 2 0", y4, idx4, ov4);
    end
    en4 = 1; mode4 = 1; div4 = 8'd2;
    push_exp(2, cyc + 1);
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y4 !== 4'b0 || idx4 !== 2'd0 || ov4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_scan got y=%b idx=%0d ov=%b required 0000 0 0", y4, idx4, ov4);
    end
    tick;
    rst_n = 1'b1;
    push_exp(0, cyc + 1);
    tick; tick;
    en4 = 0;
    tick;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL transitions_drain pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_direct_sweep;
    test_back_to_back;
    test_out_of_range;
    test_scan_wrap;
    test_div_change;
    test_mode_transitions;
    repeat (2) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
